// File: rtl/sw_score_max_tracker_if.sv
`default_nettype none
// ============================================================================
// Module   : sw_score_max_tracker_if
// Brief    : Controller/PE-array handshake and result bus of the
//            Smith-Waterman score max tracker.
// Revision : 1.0 - initial release
// ============================================================================
interface sw_score_max_tracker_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ROW_W      = 10,
  parameter int COL_W      = 10,
  parameter int CNT_W      = 20
) ();
  logic                  i_start;
  logic                  i_abort;
  logic                  i_valid;
  logic [DATA_WIDTH-1:0] i_score;
  logic [ROW_W-1:0]      i_row;
  logic [COL_W-1:0]      i_col;
  logic                  i_last;
  logic                  o_ready;
  logic                  o_busy;
  logic                  o_done;
  logic [DATA_WIDTH-1:0] o_best_score;
  logic [ROW_W-1:0]      o_best_row;
  logic [COL_W-1:0]      o_best_col;
  logic [CNT_W-1:0]      o_count;

  // Controller / PE-array side
  modport master (
    output i_start, i_abort, i_valid, i_score, i_row, i_col, i_last,
    input  o_ready, o_busy, o_done, o_best_score, o_best_row, o_best_col, o_count
  );

  // Tracker side
  modport slave (
    input  i_start, i_abort, i_valid, i_score, i_row, i_col, i_last,
    output o_ready, o_busy, o_done, o_best_score, o_best_row, o_best_col, o_count
  );
endinterface
`default_nettype wire

// File: rtl/sw_score_max_tracker.sv
`default_nettype none
// ============================================================================
// Module   : sw_score_max_tracker
// Brief    : Tracks the best signed Smith-Waterman cell score and its (row,col)
//            over one alignment, with a start/run/drain/done handshake and a
//            register stage ahead of the signed compare.
// Revision : 1.0 - initial release
// ============================================================================
module sw_score_max_tracker #(
  parameter int DATA_WIDTH = 16,
  parameter int ROW_W      = 10,
  parameter int COL_W      = 10,
  parameter int CNT_W      = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sw_score_max_tracker_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]            state;

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_score;
  logic [ROW_W-1:0]      s1_row;
  logic [COL_W-1:0]      s1_col;

  logic [DATA_WIDTH-1:0] best_score;
  logic [ROW_W-1:0]      best_row;
  logic [COL_W-1:0]      best_col;
  logic [CNT_W-1:0]      count;

  logic                  start_run;
  logic                  accept;
  logic                  s1_gt;

  // An abort squashes any sample offered in the same cycle, so a cancelled
  // alignment never counts or compares the sample that came with the abort.
  assign start_run = (state == ST_IDLE) && bus.i_start;
  assign accept    = (state == ST_RUN) && bus.i_valid && !bus.i_abort;

  // Signed compare: differing signs decide on the MSB alone, equal signs fall
  // through to an unsigned compare of the remaining bits.
  always_comb begin
    s1_gt = 1'b0;
    if (s1_score[DATA_WIDTH-1] != best_score[DATA_WIDTH-1]) begin
      s1_gt = best_score[DATA_WIDTH-1];
    end else begin
      s1_gt = (s1_score[DATA_WIDTH-2:0] > best_score[DATA_WIDTH-2:0]);
    end
  end

  // Control FSM: IDLE -> RUN -> DRAIN -> DONE -> IDLE, abort back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (bus.i_start) state <= ST_RUN;
        ST_RUN: begin
          if (bus.i_abort)              state <= ST_IDLE;
          else if (accept && bus.i_last) state <= ST_DRAIN;
        end
        ST_DRAIN: state <= bus.i_abort ? ST_IDLE : ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Stage 1: capture each accepted sample; valid bit follows acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_score <= '0;
      s1_row   <= '0;
      s1_col   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_score <= bus.i_score;
        s1_row   <= bus.i_row;
        s1_col   <= bus.i_col;
      end
    end
  end

  // Stage 2: keep the strictly greater score; ties keep the earlier coordinate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_score <= '0;
      best_row   <= '0;
      best_col   <= '0;
    end else if (start_run) begin
      best_score <= '0;
      best_row   <= '0;
      best_col   <= '0;
    end else if (s1_valid && s1_gt) begin
      best_score <= s1_score;
      best_row   <= s1_row;
      best_col   <= s1_col;
    end
  end

  // Accepted-sample counter, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (start_run) begin
      count <= '0;
    end else if (accept && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

  assign bus.o_ready      = (state == ST_RUN);
  assign bus.o_busy       = (state == ST_RUN) || (state == ST_DRAIN);
  assign bus.o_done       = (state == ST_DONE);
  assign bus.o_best_score = best_score;
  assign bus.o_best_row   = best_row;
  assign bus.o_best_col   = best_col;
  assign bus.o_count      = count;

endmodule
`default_nettype wire

// File: tb/tb_sw_score_max_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_sw_score_max_tracker
// Brief    : Self-checking bench for sw_score_max_tracker: directed scenarios
//            with literal expectations plus randomized alignments, all checked
//            every cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sw_score_max_tracker;
  localparam int DW = 16;
  localparam int RW = 10;
  localparam int CW = 10;
  localparam int NW = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  bit   cmp_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sw_score_max_tracker_if #(.DATA_WIDTH(DW), .ROW_W(RW), .COL_W(CW), .CNT_W(NW)) bus ();

  sw_score_max_tracker #(.DATA_WIDTH(DW), .ROW_W(RW), .COL_W(CW), .CNT_W(NW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 run, 2 drain, 3 done. Accepted samples of the current
  // alignment are queued; the best is visible one edge after acceptance.
  int          phase   = 0;
  int          vis     = 0;
  int          m_count = 0;
  logic [DW-1:0] q_score[$];
  logic [RW-1:0] q_row[$];
  logic [CW-1:0] q_col[$];

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      phase = 0; vis = 0; m_count = 0;
      q_score.delete(); q_row.delete(); q_col.delete();
    end else begin
      vis = q_score.size();
      case (phase)
        0: if (bus.i_start) begin
             phase = 1; vis = 0; m_count = 0;
             q_score.delete(); q_row.delete(); q_col.delete();
           end
        1: if (bus.i_abort) phase = 0;
           else if (bus.i_valid) begin
             q_score.push_back(bus.i_score);
             q_row.push_back(bus.i_row);
             q_col.push_back(bus.i_col);
             if (m_count < (1 << NW) - 1) m_count++;
             if (bus.i_last) phase = 2;
           end
        2: phase = bus.i_abort ? 0 : 3;
        default: phase = 0;
      endcase
    end
  end

  function automatic void model_best(output logic [DW-1:0] b, output logic [RW-1:0] r,
                                     output logic [CW-1:0] c);
    b = '0; r = '0; c = '0;
    for (int i = 0; i < vis; i++) begin
      if ($signed(q_score[i]) > $signed(b)) begin
        b = q_score[i]; r = q_row[i]; c = q_col[i];
      end
    end
  endfunction

  // Per-cycle comparison of every output against the model.
  initial forever begin
    logic [DW-1:0] eb;
    logic [RW-1:0] er;
    logic [CW-1:0] ec;
    @(negedge clk);
    if (cmp_en) begin
      model_best(eb, er, ec);
      chk("m_ready", bus.o_ready, (phase == 1));
      chk("m_busy",  bus.o_busy,  (phase == 1 || phase == 2));
      chk("m_done",  bus.o_done,  (phase == 3));
      chk("m_best",  bus.o_best_score, eb);
      chk("m_row",   bus.o_best_row, er);
      chk("m_col",   bus.o_best_col, ec);
      chk("m_count", bus.o_count, m_count);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic s, input logic a, input logic v, input logic [DW-1:0] sc,
                       input logic [RW-1:0] r, input logic [CW-1:0] c, input logic l);
    @(negedge clk);
    bus.i_start = s; bus.i_abort = a; bus.i_valid = v;
    bus.i_score = sc; bus.i_row = r; bus.i_col = c; bus.i_last = l;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, '0, '0, '0, 0);
  endtask

  task automatic samp(input logic [DW-1:0] sc, input logic [RW-1:0] r,
                      input logic [CW-1:0] c, input logic l);
    drive(0, 0, 1, sc, r, c, l);
  endtask

  // Counts negedges after the last sample until o_done is seen (bounded).
  task automatic wait_done(input string name);
    int k = 0;
    bit seen = 0;
    while (k < 6 && !seen) begin
      idle(1);
      k++;
      if (bus.o_done) seen = 1;
    end
    chk(name, k, 2);
  endtask

  task automatic lit(input string name, input logic [DW-1:0] b, input logic [RW-1:0] r,
                     input logic [CW-1:0] c, input int n);
    chk({name, "_best"},  bus.o_best_score, b);
    chk({name, "_row"},   bus.o_best_row, r);
    chk({name, "_col"},   bus.o_best_col, c);
    chk({name, "_count"}, bus.o_count, n);
  endtask

  initial begin
    bus.i_start = 0; bus.i_abort = 0; bus.i_valid = 0;
    bus.i_score = '0; bus.i_row = '0; bus.i_col = '0; bus.i_last = 0;
    #2 rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    chk("rst_ready", bus.o_ready, 0);
    chk("rst_busy",  bus.o_busy, 0);
    lit("rst", 16'h0, 10'd0, 10'd0, 0);

    // Basic max with a tie
    drive(1, 0, 0, '0, '0, '0, 0);
    samp(16'd5, 0, 0, 0);
    samp(16'd12, 0, 1, 0);
    samp(16'hFFFD, 0, 2, 0);
    samp(16'd12, 1, 0, 0);
    samp(16'd7, 1, 1, 1);
    wait_done("basic_latency");
    lit("basic", 16'd12, 10'd0, 10'd1, 5);

    // Sign extremes
    drive(1, 0, 0, '0, '0, '0, 0);
    samp(16'h8000, 2, 3, 0);
    samp(16'hFFFF, 2, 4, 0);
    samp(16'h0001, 3, 5, 0);
    samp(16'h7FFF, 4, 6, 1);
    wait_done("sign_latency");
    lit("sign", 16'h7FFF, 10'd4, 10'd6, 4);

    // All negative
    drive(1, 0, 0, '0, '0, '0, 0);
    samp(16'hFFFF, 5, 5, 0);
    samp(16'hFFFB, 6, 6, 1);
    wait_done("neg_latency");
    lit("neg", 16'h0, 10'd0, 10'd0, 2);

    // Gapped valid
    drive(1, 0, 0, '0, '0, '0, 0);
    samp(16'd3, 1, 1, 0);
    idle(1); chk("gap_ready1", bus.o_ready, 1);
    samp(16'd9, 2, 2, 0);
    idle(1); chk("gap_ready2", bus.o_ready, 1);
    samp(16'd4, 3, 3, 1);
    wait_done("gap_latency");
    lit("gap", 16'd9, 10'd2, 10'd2, 3);

    // Ignored inputs: sample in IDLE, start during RUN
    samp(16'd100, 7, 7, 0);
    idle(2);
    lit("ign_idle", 16'd9, 10'd2, 10'd2, 3);
    drive(1, 0, 0, '0, '0, '0, 0);
    samp(16'd20, 1, 2, 0);
    drive(1, 0, 1, 16'd30, 10'd1, 10'd3, 0);
    samp(16'd25, 1, 4, 1);
    wait_done("ign_latency");
    lit("ign_run", 16'd30, 10'd1, 10'd3, 3);

    // Abort after two samples, then abort coincident with last
    drive(1, 0, 0, '0, '0, '0, 0);
    samp(16'd40, 0, 1, 0);
    samp(16'd50, 0, 2, 0);
    drive(0, 1, 0, '0, '0, '0, 0);
    idle(1);
    chk("abort_busy", bus.o_busy, 0);
    drive(1, 0, 0, '0, '0, '0, 0);
    samp(16'd60, 0, 3, 0);
    drive(0, 1, 1, 16'd70, 10'd0, 10'd4, 1);
    idle(1);
    chk("abortlast_busy", bus.o_busy, 0);
    idle(3);
    drive(1, 1, 0, '0, '0, '0, 0);
    idle(1);
    chk("restart_count", bus.o_count, 0);
    chk("restart_ready", bus.o_ready, 1);
    drive(0, 1, 0, '0, '0, '0, 0);
    idle(1);

    // Async reset mid-RUN
    drive(1, 0, 0, '0, '0, '0, 0);
    samp(16'd11, 1, 1, 0);
    samp(16'd22, 2, 2, 0);
    idle(1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", bus.o_ready, 0);
    chk("arst_busy",  bus.o_busy, 0);
    chk("arst_done",  bus.o_done, 0);
    lit("arst", 16'h0, 10'd0, 10'd0, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    idle(3);
    chk("arst_idle_ready", bus.o_ready, 0);

    // Randomized alignments
    for (int t = 0; t < 30; t++) begin
      bit aborted = 0;
      int n = $urandom_range(1, 25);
      int sent = 0;
      if ($urandom_range(0, 3) == 0) samp(16'($urandom), 10'($urandom), 10'($urandom), 0);
      drive(1, 1'($urandom_range(0, 3) == 0), 0, '0, '0, '0, 0);
      while (sent < n && !aborted) begin
        logic [DW-1:0] sc;
        case ($urandom_range(0, 3))
          0: sc = 16'($urandom);
          1: sc = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
          default: sc = 16'($signed($urandom_range(0, 200)) - 100);
        endcase
        if ($urandom_range(0, 49) == 0) begin
          drive(0, 1, 1'($urandom_range(0, 1)), sc, '0, '0, 1'($urandom_range(0, 1)));
          aborted = 1;
        end else if ($urandom_range(0, 3) == 0) begin
          drive(1'($urandom_range(0, 1)), 0, 0, sc, '0, '0, 1);
        end else begin
          sent++;
          samp(sc, 10'($urandom), 10'($urandom), (sent == n));
        end
      end
      idle(4);
    end

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sw_score_max_tracker.md
Name: sw_score_max_tracker

Overview:
- Sequences the signed max-compare datapath over the stream of cell scores (V) emitted by the Smith-Waterman PE array.
- Keeps the running best local-alignment score and its (row, col) coordinate.
- Runs a start/run/done handshake with the top-level controller. A pipeline register ahead of the compare stage meets timing.
- Sits between the PE array output and the result/traceback interface.

Parameters:
DATA_WIDTH, 16, score width; two's-complement signed (matches V_E_F_Bit)
ROW_W, 10, width of query-row index
COL_W, 10, width of target-column index
CNT_W, 20, width of accepted-sample counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_start  in  1  single-cycle pulse; begin a new alignment
i_abort  in  1  single-cycle pulse; cancel current alignment
i_valid  in  1  score sample valid
i_score  in  DATA_WIDTH  signed cell score V(row,col)
i_row  in  ROW_W  row index of sample
i_col  in  COL_W  column index of sample
i_last  in  1  marks final sample of the alignment; qualified by i_valid
o_ready  out  1  tracker accepts samples (high only in RUN)
o_busy  out  1  high in RUN or DRAIN
o_done  out  1  one-cycle pulse; results final
o_best_score  out  DATA_WIDTH  best score so far
o_best_row  out  ROW_W  row of best score
o_best_col  out  COL_W  column of best score
o_count  out  CNT_W  samples accepted this alignment

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0, including o_ready, o_busy, o_done and the best/coord/count registers.
  - Pipeline valid bit is cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: i_start goes to RUN. On entering RUN, best_score/row/col and count clear to 0 and the pipeline valid bit clears.
  - RUN: o_ready=1. A sample is accepted when i_valid && o_ready. An accepted sample with i_last=1 goes to DRAIN. i_abort goes to IDLE.
  - DRAIN: o_ready=0. Stays exactly one cycle while stage 2 consumes the last sample, then goes to DONE. i_abort goes to IDLE.
  - DONE: o_done=1 for this single cycle, then goes to IDLE. Result registers hold until the next i_start.
- i_start is ignored in RUN, DRAIN and DONE.
- Any input with i_valid=1 outside RUN is dropped and not counted.
- Simultaneous i_abort and i_start in IDLE: i_start wins.
- i_abort has priority over an accepted i_last in the same cycle: go to IDLE, no o_done. Result registers keep their partial values.
- Pipeline:
  - Stage 1 registers {valid, score, row, col} on acceptance.
  - Stage 2 compares the stage-1 score with best_score as a signed two's-complement compare: MSB-first sign decision, then magnitude of the lower DATA_WIDTH-1 bits.
  - Update best_score/row/col only if stage-1 score is strictly greater. Ties keep the earliest coordinate.
  - Negative scores never replace the initial 0.
- o_count increments on each accepted sample and saturates at all-ones.
- Latency:
  - Sample accepted at cycle N is reflected in o_best_* at the N+2 edge.
  - i_last accepted at edge N gives DRAIN during N..N+1, DONE (o_done=1) during N+1..N+2, and o_best_* final when o_done is high.
- Back-to-back samples every cycle are supported. i_valid gaps in RUN are allowed and do not change state.
- o_busy = (state==RUN)||(state==DRAIN).
- Reset mid-operation aborts immediately. No o_done.

Test Plan:
- Basic max: start, then scores 5,12,-3,12,7 at (0,0),(0,1),(0,2),(1,0),(1,1), last on 5th -> o_done 2 cycles after last accept; best=12 at (0,1) (tie keeps first); count=5.
- Sign handling: scores 16'h8000, 16'hFFFF, 16'h0001, 16'h7FFF -> best=16'h7FFF at its coord; all-negative stream (-1,-5, last) -> best=0, row=col=0.
- Gapped valid: samples with i_valid toggling 1,0,1,0,1 (last on 3rd valid) -> count=3, o_done one cycle after DRAIN, o_ready never drops in RUN.
- Abort: abort during RUN after 2 samples, and abort coincident with i_last -> state IDLE, o_done never pulses, o_busy=0 next cycle; subsequent start clears count to 0.
- Ignored inputs: i_valid with data 100 in IDLE, plus i_start during RUN -> no count change, no restart; best unaffected.
- Async reset: assert rst_n low mid-RUN between clock edges -> all outputs 0 immediately; after release, idle with o_ready=0 until i_start.
